// File: rtl/demux_lane_scheduler.sv
// demux_lane_scheduler
//   Round-robin dispatcher for a 1:8 lane demux. It accepts words on a valid/ready
//   input, picks a destination lane per word and holds the word on registered
//   outputs (lane_valid/lane_data/sel) until that lane takes it.
//   BURST_LEN consecutive words go to one lane before the round-robin pointer moves.
//   Optional feature macro: DEMUX_SCHED_MASK_EN adds a lane_en[7:0] eligibility mask.
module demux_lane_scheduler #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [7:0]        lane_ready,
`ifdef DEMUX_SCHED_MASK_EN
  input  logic [7:0]        lane_en,
`endif
  output logic [7:0]        lane_valid,
  output logic [DATA_W-1:0] lane_data,
  output logic [2:0]        sel,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Burst counter value at which the pointer moves on to the next lane.
  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic [2:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        lane_valid_q, lane_valid_d;

  logic [7:0] elig;
  logic       any_elig;
  logic [2:0] target;
  logic       accept;
  logic       delivered;
  logic [7:0] cnt_eff;

`ifdef DEMUX_SCHED_MASK_EN
  assign elig = lane_en;
`else
  assign elig = 8'hFF;
`endif

  assign any_elig  = |elig;
  assign delivered = (state_q == HOLD) && lane_ready[sel_q];
  assign in_ready  = any_elig && ((state_q == IDLE) || lane_ready[sel_q]);
  assign accept    = in_valid && in_ready;

  // Target lane: first eligible lane scanning upward from the pointer, wrapping 7->0.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    logic [2:0] idx;
    logic       found;
    target = ptr_q;
    idx    = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && elig[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

  // Datapath and round-robin bookkeeping updated on each accepted word.
  always_comb begin
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    sel_d       = sel_q;
    data_d      = data_q;
    cnt_eff     = (target == ptr_q) ? burst_cnt_q : 8'd0;
    if (accept) begin
      data_d = in_data;
      sel_d  = target;
      if (cnt_eff == BURST_LAST) begin
        burst_cnt_d = 8'd0;
        ptr_d       = target + 3'd1;
      end else begin
        burst_cnt_d = cnt_eff + 8'd1;
        ptr_d       = target;
      end
    end
  end

  // FSM next state: a held word leaves only when its lane is ready; a same-cycle
  // accept refills the hold register with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = HOLD;
      end
      HOLD: begin
        if (delivered) state_d = accept ? HOLD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot lane valid is derived from next state so the output comes from a flop.
  always_comb begin
    lane_valid_d = (state_d == HOLD) ? (8'b1 << sel_d) : 8'd0;
  end

  // State and output registers; async reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 3'd0;
      burst_cnt_q  <= 8'd0;
      sel_q        <= 3'd0;
      data_q       <= '0;
      lane_valid_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      lane_valid_q <= lane_valid_d;
    end
  end

  assign lane_valid = lane_valid_q;
  assign lane_data  = data_q;
  assign sel        = sel_q;
  assign busy       = (state_q == HOLD);

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Testbench for demux_lane_scheduler: a BURST_LEN=1 instance carries most scenarios,
// a BURST_LEN=2 instance covers burst grouping. Expected lane/data pairs are queued
// when a word is offered and compared when the DUT delivers it.
module tb_demux_lane_scheduler;

  typedef struct {
    logic [2:0] lane;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_valid2;
  logic [7:0] in_data, in_data2;
  logic       in_ready, in_ready2;
  logic [7:0] lane_ready, lane_ready2;
  logic [7:0] lane_en;
  logic [7:0] lane_valid, lane_valid2;
  logic [7:0] lane_data, lane_data2;
  logic [2:0] sel, sel2;
  logic       busy, busy2;

  exp_t sb_q[$];
  exp_t sb2_q[$];
  int   checks = 0;
  int   errors = 0;

  demux_lane_scheduler #(.DATA_W(8), .BURST_LEN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .lane_ready(lane_ready),
`ifdef DEMUX_SCHED_MASK_EN
    .lane_en(lane_en),
`endif
    .lane_valid(lane_valid), .lane_data(lane_data), .sel(sel), .busy(busy)
  );

  demux_lane_scheduler #(.DATA_W(8), .BURST_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .lane_ready(lane_ready2),
`ifdef DEMUX_SCHED_MASK_EN
    .lane_en(lane_en),
`endif
    .lane_valid(lane_valid2), .lane_data(lane_data2), .sel(sel2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delivery monitor for the BURST_LEN=1 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (busy && lane_valid !== (8'b1 << sel)) begin
        errors++;
        $display("FAIL lane_valid_onehot: got %h expected %h", lane_valid, 8'b1 << sel);
      end else if (!busy && lane_valid !== 8'h00) begin
        errors++;
        $display("FAIL lane_valid_idle: got %h expected 00", lane_valid);
      end
      if (busy && lane_ready[sel]) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_delivery: sel=%0d data=%h with empty scoreboard", sel, lane_data);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (sel !== e.lane || lane_data !== e.data) begin
            errors++;
            $display("FAIL delivery: got lane %0d data %h expected lane %0d data %h",
                     sel, lane_data, e.lane, e.data);
          end
        end
      end
    end
  end

  // Delivery monitor for the BURST_LEN=2 instance.
  always @(negedge clk) begin
    if (rst_n && busy2 && lane_ready2[sel2]) begin
      checks++;
      if (sb2_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_delivery2: sel=%0d data=%h", sel2, lane_data2);
      end else begin
        exp_t e;
        e = sb2_q.pop_front();
        if (sel2 !== e.lane || lane_data2 !== e.data || lane_valid2 !== (8'b1 << e.lane)) begin
          errors++;
          $display("FAIL burst_delivery: got lane %0d data %h valid %h expected lane %0d data %h",
                   sel2, lane_data2, lane_valid2, e.lane, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    in_data    = 8'h00;
    in_data2   = 8'h00;
    lane_ready = 8'hFF;
    lane_ready2 = 8'hFF;
    lane_en    = 8'hFF;
    sb_q.delete();
    sb2_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Offer one word; it is accepted at the first edge where in_ready is high.
  // Leaves in_valid asserted so consecutive calls stream back-to-back.
  task automatic send(input logic [7:0] d, input logic [2:0] lane, input bit must_be_ready);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %h never accepted", d);
      @(posedge clk); #1;
      return;
    end
    if (must_be_ready) begin
      checks++;
      if (waited != 0) begin
        errors++;
        $display("FAIL in_ready_stall: word %h waited %0d cycles expected 0", d, waited);
      end
    end
    sb_q.push_back('{lane: lane, data: d});
    @(posedge clk); #1;
  endtask

  task automatic drain_check(input string name);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words undelivered expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; in_data = 8'h00; in_data2 = 8'h00;
    lane_ready = 8'hFF; lane_ready2 = 8'hFF; lane_en = 8'hFF;
    #2;
    checks++;
    if (lane_valid !== 8'h00 || lane_data !== 8'h00 || sel !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%h data=%h sel=%0d busy=%b expected 00 00 0 0",
               lane_valid, lane_data, sel, busy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [2:0] l;
    do_reset();
    l = 3'd0;
    for (int i = 0; i < 10; i++) begin
      send(8'h20 + 8'(i), l, 1'b1);
      l = l + 3'd1;
    end
    drain_check("round_robin");
  endtask

  task automatic test_burst();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid2 = 1'b1;
      in_data2  = 8'hA + 8'(i);
      @(negedge clk);
      checks++;
      if (in_ready2 !== 1'b1) begin
        errors++;
        $display("FAIL burst_in_ready: word %0d got %b expected 1", i, in_ready2);
      end
      sb2_q.push_back('{lane: 3'(i / 2), data: 8'hA + 8'(i)});
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb2_q.size() != 0) begin
      errors++;
      $display("FAIL burst_drain: %0d words undelivered expected 0", sb2_q.size());
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h40 + 8'(i), 3'(i), 1'b1);
    send(8'h5A, 3'd3, 1'b1);
    // Lane 3 stalls; lane 5 ready must not matter. A new word waits at the input.
    lane_ready = 8'h20;
    in_data    = 8'h77;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (lane_valid !== 8'h08 || lane_data !== 8'h5A || sel !== 3'd3 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d valid=%h data=%h sel=%0d expected 08 5A 3",
                 c, lane_valid, lane_data, sel);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_in_ready: cycle %0d got %b expected 0", c, in_ready);
      end
    end
    @(posedge clk); #1;
    lane_ready = 8'hFF;
    send(8'h77, 3'd4, 1'b1);
    drain_check("hold");
  endtask

`ifdef DEMUX_SCHED_MASK_EN
  task automatic test_mask();
    do_reset();
    lane_en = 8'b1000_0100;
    send(8'h61, 3'd2, 1'b1);
    send(8'h62, 3'd7, 1'b1);
    send(8'h63, 3'd2, 1'b1);
    send(8'h64, 3'd7, 1'b1);
    drain_check("mask");
  endtask

  task automatic test_mask_none();
    do_reset();
    lane_en  = 8'h00;
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || lane_valid !== 8'h00) begin
        errors++;
        $display("FAIL mask_none: in_ready=%b lane_valid=%h expected 0 00", in_ready, lane_valid);
      end
    end
    @(posedge clk); #1;
    lane_en = 8'h01;
    send(8'h99, 3'd0, 1'b1);
    drain_check("mask_none");
  endtask
`endif

  task automatic test_reset_mid_hold();
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 3'(i), 1'b1);
    send(8'h55, 3'd5, 1'b1);
    lane_ready = 8'h00;
    in_valid   = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sel !== 3'd5) begin
      errors++;
      $display("FAIL pre_reset_hold: busy=%b sel=%0d expected 1 5", busy, sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (lane_valid !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || lane_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: valid=%h sel=%0d busy=%b data=%h expected 00 0 0 00",
               lane_valid, sel, busy, lane_data);
    end
    sb_q.delete();
    @(posedge clk); #1;
    rst_n      = 1'b1;
    lane_ready = 8'hFF;
    send(8'h33, 3'd0, 1'b1);
    drain_check("post_reset");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_hold();
`ifdef DEMUX_SCHED_MASK_EN
    test_mask();
    test_mask_none();
`endif
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
